// File: rtl/raybox_debounce.sv
// rtl/raybox_debounce.sv - synchronise, debounce and edge-detect raw pushbutton pins
// Per channel: polarity fix, 2-flop sync, stable-run counter, press/release strobes, per-frame sticky flag.
module raybox_debounce #(
  parameter int N_BUTTONS       = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic                 frame_tick,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] frame_press
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] btn_norm;
  logic [N_BUTTONS-1:0] sync1_q;
  logic [N_BUTTONS-1:0] sync2_q;
  logic [N_BUTTONS-1:0] level_q, level_d;
  logic [N_BUTTONS-1:0] press_q, press_d;
  logic [N_BUTTONS-1:0] release_q, release_d;
  logic [N_BUTTONS-1:0] fpress_q, fpress_d;
  logic [CW-1:0]        cnt_q [N_BUTTONS];
  logic [CW-1:0]        cnt_d [N_BUTTONS];

  // Normalise before the synchroniser so its reset value of 0 means "not pressed".
  assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Set beats clear so a press landing on the tick is carried into the next frame.
    fpress_d = press_q | (fpress_q & ~{N_BUTTONS{frame_tick}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      fpress_q  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_norm;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      fpress_q  <= fpress_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign frame_press = fpress_q;

endmodule

// File: tb/tb_raybox_debounce.sv
// tb/tb_raybox_debounce.sv - directed and random checks of raybox_debounce against a windowed reference model
module tb_raybox_debounce;

  localparam int N  = 6;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_raw;
  logic         frame_tick;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] frame_press;

  raybox_debounce #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .frame_tick (frame_tick),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .frame_press(frame_press)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int pcount [N];

  // Reference: a channel flips once its last DC synchronised samples all disagree with its level.
  logic [N-1:0]  m_p1, m_p2, m_lvl, m_press, m_rel, m_fp;
  logic [DC-1:0] m_win [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_fp = '0;
    for (int c = 0; c < N; c++) m_win[c] = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] np, nr, nl;
    logic         flip;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      m_win[c] = {m_win[c][DC-2:0], m_p2[c]};
      flip     = (m_win[c] == {DC{~m_lvl[c]}});
      np[c]    = flip & ~m_lvl[c];
      nr[c]    = flip & m_lvl[c];
      nl[c]    = m_lvl[c] ^ flip;
    end
    m_fp    = m_press | (m_fp & ~{N{frame_tick}});
    m_press = np;
    m_rel   = nr;
    m_lvl   = nl;
    m_p2    = m_p1;
    m_p1    = ~btn_raw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("level",   32'(btn_level),   32'(m_lvl));
    chk("press",   32'(btn_press),   32'(m_press));
    chk("release", 32'(btn_release), 32'(m_rel));
    chk("fpress",  32'(frame_press), 32'(m_fp));
    for (int c = 0; c < N; c++) if (btn_press[c] === 1'b1) pcount[c]++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic until_level(input int ch, input logic val, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (btn_level[ch] !== val && n < 40);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    int n, p0, p5;
    for (int c = 0; c < N; c++) pcount[c] = 0;
    model_reset();

    // Reset with every pin pressed, then release
    reset_n    = 1'b0;
    btn_raw    = 6'h00;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_press", 32'(btn_press), 0);
    chk("rst_fp",    32'(frame_press), 0);
    reset_n = 1'b1;
    until_level(0, 1'b1, n);
    chk("rst_latency", n, 10);
    chk("rst_level_all", 32'(btn_level), 32'h3F);
    chk("rst_press_all", 32'(btn_press), 32'h3F);
    step();
    chk("rst_press_single", 32'(btn_press), 0);

    // Release everything, then clean press/release on bit 2
    btn_raw = 6'h3F;
    steps(12);
    tick_pulse();
    btn_raw[2] = 1'b0;
    until_level(2, 1'b1, n);
    chk("b2_press_latency", n, 10);
    chk("b2_press_strobe", 32'(btn_press), 32'h04);
    steps(10);
    btn_raw[2] = 1'b1;
    until_level(2, 1'b0, n);
    chk("b2_release_latency", n, 10);
    chk("b2_release_strobe", 32'(btn_release), 32'h04);
    steps(4);

    // Bounce on bit 0: runs of 3, 7, 5 with single idle gaps are rejected
    p0 = pcount[0];
    btn_raw[0] = 1'b0; steps(3); btn_raw[0] = 1'b1; steps(1);
    btn_raw[0] = 1'b0; steps(7); btn_raw[0] = 1'b1; steps(1);
    btn_raw[0] = 1'b0; steps(5); btn_raw[0] = 1'b1; steps(4);
    chk("bounce_level", 32'(btn_level[0]), 0);
    chk("bounce_nopress", pcount[0] - p0, 0);
    btn_raw[0] = 1'b0;
    steps(14);
    chk("bounce_hold_press", pcount[0] - p0, 1);
    btn_raw[0] = 1'b1;
    steps(12);

    // Frame tick coinciding with btn_press[1]
    tick_pulse();
    btn_raw[1] = 1'b0;
    n = 0;
    do begin step(); n++; end while (btn_press[1] !== 1'b1 && n < 40);
    chk("b1_press_seen", 32'(btn_press[1]), 1);
    tick_pulse();
    chk("collide_fp_kept", 32'(frame_press[1]), 1);
    steps(3);
    chk("collide_fp_hold", 32'(frame_press[1]), 1);
    tick_pulse();
    chk("collide_fp_clear", 32'(frame_press[1]), 0);
    btn_raw[1] = 1'b1;
    steps(12);

    // Two press/release cycles on bit 5 within one frame
    tick_pulse();
    p5 = pcount[5];
    for (int r = 0; r < 2; r++) begin
      btn_raw[5] = 1'b0; steps(12);
      btn_raw[5] = 1'b1; steps(12);
    end
    chk("b5_two_presses", pcount[5] - p5, 2);
    chk("b5_fp_before_tick", 32'(frame_press[5]), 1);
    tick_pulse();
    chk("b5_fp_after_tick", 32'(frame_press[5]), 0);

    // Reset in the middle of a count on bit 3
    btn_raw[3] = 1'b0;
    steps(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_level", 32'(btn_level), 0);
    chk("midrst_fp", 32'(frame_press), 0);
    steps(2);
    reset_n = 1'b1;
    until_level(3, 1'b1, n);
    chk("midrst_latency", n, 10);
    chk("midrst_press", 32'(btn_press), 32'h08);
    btn_raw[3] = 1'b1;
    steps(12);

    // Random pin activity and frame ticks
    for (int seg = 0; seg < 200; seg++) begin
      int hold;
      btn_raw = 6'($urandom);
      hold    = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        frame_tick = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    frame_tick = 1'b0;
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/raybox_debounce.md
# raybox_debounce

Button-conditioning stage directly upstream of the `raybox` core on the DE0-Nano build. Takes raw pulled-high pushbutton pins (onboard `KEY[1:0]`, external `K4..K1` on GPIO1) and synchronises and debounces each one. Emits active-high debounced levels, one-cycle press/release strobes, and per-frame sticky press flags. The core samples these once per video frame, so a short tap is never missed between frames.

## Interface

Parameters:
- `N_BUTTONS`, default 6: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a change (10 ms at 25 MHz). Legal range ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means the raw pin reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- `clk` in 1: pixel-domain clock, the same clock that drives `raybox`.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `btn_raw` in N_BUTTONS: raw asynchronous button pins.
- `frame_tick` in 1: one-cycle strobe per video frame, synchronous to `clk`.
- `btn_level` out N_BUTTONS: debounced state, active-high (1 = pressed).
- `btn_press` out N_BUTTONS: one-cycle pulse when `btn_level` rises.
- `btn_release` out N_BUTTONS: one-cycle pulse when `btn_level` falls.
- `frame_press` out N_BUTTONS: sticky flag; set by a press, cleared by `frame_tick`.

## Operation

- **Polarity.** Each raw bit is normalised to active-high (inverted when `ACTIVE_LOW`=1) before synchronisation.
- **Synchroniser.** Two flops per channel, reset to 0 (not pressed). `s2` is the synchronised value.
- **Debounce counter.** Each channel has its own counter of width clog2(DEBOUNCE_CYCLES), reset to 0.
  - `s2 == btn_level`: the counter clears to 0.
  - `s2 != btn_level` and counter < DEBOUNCE_CYCLES-1: the counter increments.
  - `s2 != btn_level` and counter == DEBOUNCE_CYCLES-1: on that edge `btn_level` takes `s2` and the counter clears.
- **Glitch rejection.** Any mismatch run shorter than DEBOUNCE_CYCLES is discarded. The counter never wraps.
- **Edge strobes.** These are registered on the same edge `btn_level` changes, so they are high exactly for the first cycle of the new level.
  - `btn_press` = rising transition.
  - `btn_release` = falling transition.
  - Never both high on the same channel in the same cycle.
- **Frame flags.** Per channel, `frame_press` is set by `btn_press` and cleared by `frame_tick`.
  - If both occur in the same cycle, set wins and the flag stays 1, so the press is carried into the next frame.
  - A press and release within one frame still leaves `frame_press`=1 until the next `frame_tick`.
- **Independence.** Channels are fully independent; no priority or interlock between buttons.

## Timing

- **Reset values.** All outputs are 0 while `reset_n`=0. Synchroniser flops, counters and flags are all 0.
- **Release from reset.** Deassertion is synchronised externally by the wrapper. The first active edge after release is edge E0.
- **Latency.** Suppose a raw change is stable before edge E0 and held. Then `s2` reflects it after E1, and `btn_level`, `btn_press`/`btn_release` change after edge E(DEBOUNCE_CYCLES+1). Total is DEBOUNCE_CYCLES+2 edges, including E0.
- **`frame_press` lag.** `frame_press` rises one cycle after `btn_press`, i.e. the edge after the strobe.
- **Reset mid-operation.** Asserting `reset_n` mid-count aborts it immediately. After release, a still-held button needs a full DEBOUNCE_CYCLES+2 edges to appear as pressed, and it generates `btn_press`.
- **No combinational paths.** There is no combinational path from any input to any output.

## Test plan

All scenarios use DEBOUNCE_CYCLES=8, N_BUTTONS=6, ACTIVE_LOW=1.

1. **Reset:** hold `reset_n`=0 with `btn_raw`=6'b000000 (all pressed). All outputs are 0. Release reset; `btn_level`=6'h3F appears exactly 10 edges later, with a single `btn_press`=6'h3F pulse.
2. **Clean press/release on bit 2:** drive `btn_raw[2]` 1→0 and hold 20 cycles.
   - `btn_level[2]` rises at edge 10 and `btn_press[2]` is high for 1 cycle.
   - Return the pin to 1: `btn_release[2]` pulses 10 edges later. No other bits toggle.
3. **Bounce:** on bit 0, drive pressed runs of 3, 7 and 5 cycles separated by 1-cycle idle gaps. `btn_level[0]` stays 0 and no strobes fire.
   - Then hold pressed for 8+ cycles: exactly one `btn_press[0]`.
4. **Frame flag collision:** pulse `frame_tick` on the same cycle as `btn_press[1]`. `frame_press[1]` stays 1 after the tick and clears only on the next `frame_tick`.
5. **Multiple presses in one frame:** on bit 5, two full press/release cycles occur between ticks. `frame_press[5]`=1 at the tick; 0 after it.
6. **Mid-count reset:** press bit 3, then assert `reset_n` after 5 cycles. Outputs go 0 asynchronously. After release with the pin still held, the press is recognised 10 edges later.
